// File: rtl/arb_types.sv
// Shared types for the memory port arbiter.
// FSM state encoding and the full byte-enable mask.
package arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] ARB_BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of back-to-back data grants won while a fetch waited.
// Flags when the streak has reached the configured limit.
module mem_arb_streak_ctr #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_ge_max
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_D_STREAK);

    logic [3:0] r_count;

    // Clear on a fetch grant, otherwise count up and stick at 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_inc && (r_count != 4'hF)) begin
            r_count <= r_count + 4'd1;
        end
    end

    // Limit reached: a pending fetch now beats the data side.
    always_comb begin
        o_ge_max = (r_count >= MAX_CNT);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Data has priority; a streak limit keeps fetch from starving.
module mem_port_arbiter
    import arb_types::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic        i_resp,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_enable,
    output logic        d_resp,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_next;

    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;

    logic w_d_req;
    logic w_i_req;
    logic w_idle;
    logic w_grant_d;
    logic w_grant_i;
    logic w_done;
    logic w_ge_max;

    // Requests are only looked at in IDLE; data wins unless the streak is spent.
    always_comb begin
        w_d_req   = d_read | d_write;
        w_i_req   = i_read;
        w_idle    = (r_state == ARB_IDLE);
        w_grant_d = w_idle & w_d_req & (~w_i_req | ~w_ge_max);
        w_grant_i = w_idle & ~w_grant_d & w_i_req;
        w_done    = ~w_idle & mem_resp;
    end

    mem_arb_streak_ctr #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_grant_d & w_i_req),
        .i_clr    (w_grant_i),
        .o_ge_max (w_ge_max)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: grant from IDLE, return to IDLE after the memory answers.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_grant_d) begin
                    w_next = ARB_SERVE_D;
                end else if (w_grant_i) begin
                    w_next = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I,
            ARB_SERVE_D: begin
                if (mem_resp) begin
                    w_next = ARB_IDLE;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    // Route the memory completion to the side that owns the port.
    always_comb begin
        i_resp  = (r_state == ARB_SERVE_I) & mem_resp;
        d_resp  = (r_state == ARB_SERVE_D) & mem_resp;
        i_rdata = i_resp ? mem_rdata : 32'h0;
        d_rdata = d_resp ? mem_rdata : 32'h0;
    end

    // Latch the winner; strobes drop on the edge that ends the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_be      <= ARB_BE_FULL;
        end else if (w_grant_d) begin
            r_mem_read    <= d_read & ~d_write;
            r_mem_write   <= d_write;
            r_mem_address <= d_addr;
            r_mem_wdata   <= d_wdata;
            r_mem_be      <= d_write ? d_byte_enable : ARB_BE_FULL;
        end else if (w_grant_i) begin
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_address <= i_addr;
            r_mem_be      <= ARB_BE_FULL;
        end else if (w_done) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end
    end

    // Memory side is driven straight from the latch registers.
    always_comb begin
        mem_read        = r_mem_read;
        mem_write       = r_mem_write;
        mem_address     = r_mem_address;
        mem_wdata       = r_mem_wdata;
        mem_byte_enable = r_mem_be;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Grants are checked against a queue of expected memory accesses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic        i_resp;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic        d_resp;
    logic [31:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          is_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    mem_port_arbiter #(
        .MAX_D_STREAK (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_read          (i_read),
        .i_addr          (i_addr),
        .i_resp          (i_resp),
        .i_rdata         (i_rdata),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_byte_enable   (d_byte_enable),
        .d_resp          (d_resp),
        .d_rdata         (d_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        exp_t e;
        e.is_d  = is_d;
        e.rd    = rd;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.be    = be;
        q.push_back(e);
    endtask

    // Wait for a grant, compare it with the queue head, then answer it.
    task automatic serve(input logic [31:0] rdata, output int lat);
        exp_t e;
        lat = 0;
        while (!(mem_read || mem_write) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!(mem_read || mem_write)) begin
            chk("grant_timeout", 32'd0, 32'd1);
            return;
        end
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk("mem_read", 32'(mem_read), 32'(e.rd));
        chk("mem_write", 32'(mem_write), 32'(e.wr));
        chk("mem_address", mem_address, e.addr);
        if (e.is_d) chk("mem_wdata", mem_wdata, e.wdata);
        chk("mem_be", 32'(mem_byte_enable), 32'(e.be));
        mem_rdata = 32'hBAD0_0BAD;
        #1;
        chk("resp_early", 32'(i_resp | d_resp), 32'd0);
        chk("rdata_early", i_rdata | d_rdata, 32'd0);
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        #1;
        chk("i_resp", 32'(i_resp), 32'(!e.is_d));
        chk("d_resp", 32'(d_resp), 32'(e.is_d));
        chk("i_rdata", i_rdata, e.is_d ? 32'h0 : rdata);
        chk("d_rdata", d_rdata, e.is_d ? rdata : 32'h0);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        chk("strobe_clear", 32'(mem_read | mem_write), 32'd0);
        chk("resp_one_cycle", 32'(i_resp | d_resp), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Reset with both requests held.
        rst           = 1'b0;
        i_read        = 1'b1;
        i_addr        = 32'h10;
        d_read        = 1'b1;
        d_write       = 1'b0;
        d_addr        = 32'h20;
        d_wdata       = 32'h0;
        d_byte_enable = 4'b0101;
        mem_resp      = 1'b0;
        mem_rdata     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", 32'(mem_byte_enable), 32'hF);
        chk("rst_resp", 32'(i_resp | d_resp), 32'd0);
        push(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'b1111);
        rst = 1'b1;
        serve(32'hAAAA_5555, lat);
        chk("t1_latency", 32'(lat), 32'd1);
        i_read = 1'b0;
        d_read = 1'b0;

        // Simple fetch.
        @(negedge clk);
        i_read = 1'b1;
        i_addr = 32'h60;
        push(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'b1111);
        serve(32'h0000_0013, lat);
        chk("t2_latency", 32'(lat), 32'd1);
        i_read = 1'b0;

        // Store; address change mid-transaction must not leak.
        @(negedge clk);
        d_write       = 1'b1;
        d_addr        = 32'h100;
        d_wdata       = 32'hDEAD_BEEF;
        d_byte_enable = 4'b0011;
        push(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        d_addr  = 32'h104;
        d_wdata = 32'h0;
        @(negedge clk);
        serve(32'h0, lat);
        d_write = 1'b0;

        // Contention: D x4 then I, twice.
        @(negedge clk);
        i_read  = 1'b1;
        i_addr  = 32'h200;
        d_read  = 1'b1;
        d_addr  = 32'h300;
        d_wdata = 32'h0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                push(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'b1111);
            push(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'b1111);
        end
        for (int n = 0; n < 10; n++) begin
            serve(32'h1000 + 32'(n), lat);
            chk("t4_latency", 32'(lat), 32'd1);
        end
        i_read = 1'b0;
        d_read = 1'b0;

        // Async reset during a store.
        @(negedge clk);
        d_write       = 1'b1;
        d_addr        = 32'h400;
        d_wdata       = 32'h5A5A_5A5A;
        d_byte_enable = 4'b1000;
        @(negedge clk);
        chk("t5_mem_write", 32'(mem_write), 32'd1);
        #3;
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("t5_write_drop", 32'(mem_write), 32'd0);
        chk("t5_no_resp", 32'(d_resp), 32'd0);
        chk("t5_addr_rst", mem_address, 32'h0);
        d_write  = 1'b0;
        @(negedge clk);
        mem_resp = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("t5_idle", 32'(mem_read | mem_write), 32'd0);
        d_read = 1'b1;
        d_addr = 32'h500;
        push(1'b1, 1'b1, 1'b0, 32'h500, 32'h5A5A_5A5A, 4'b1111);
        serve(32'h0BAD_CAFE, lat);
        chk("t5_restart_lat", 32'(lat), 32'd1);
        d_read = 1'b0;

        // Read and write together: write wins.
        @(negedge clk);
        d_read        = 1'b1;
        d_write       = 1'b1;
        d_addr        = 32'h600;
        d_wdata       = 32'h1122_3344;
        d_byte_enable = 4'b1100;
        push(1'b1, 1'b0, 1'b1, 32'h600, 32'h1122_3344, 4'b1100);
        serve(32'h0, lat);
        d_read  = 1'b0;
        d_write = 1'b0;

        // Stray mem_resp in IDLE.
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("t6_idle_i_resp", 32'(i_resp), 32'd0);
        chk("t6_idle_d_resp", 32'(d_resp), 32'd0);
        chk("t6_idle_rdata", i_rdata | d_rdata, 32'h0);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        chk("t6_no_strobe", 32'(mem_read | mem_write), 32'd0);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
